// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the state encoding and the reset fetch address.
package fetch_ctrl_pkg;
    typedef logic        u1;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam u64 PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
    localparam u64 INSTR_BYTES      = 64'd4;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-bus, redirect and decode-side handshake signals of the fetch sequencer.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    u1  ireq_valid;
    u64 ireq_addr;
    u1  iresp_data_ok;
    u32 iresp_data;
    u1  redirect_valid;
    u64 redirect_pc;
    u1  out_ready;
    u1  out_valid;
    u64 out_pc;
    u32 out_instr;

    modport master (
        output ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
        input  iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
        output iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_ctrl_pc_next.sv
// Picks the next fetch address (sequential pc or redirect target) and the
// address after it; the +4 wraps naturally at 64 bits.
module fetch_ctrl_pc_next
    import fetch_ctrl_pkg::*;
(
    input  u64 pc,
    input  u64 redirect_pc,
    input  u1  use_redirect,
    output u64 next_addr,
    output u64 next_pc
);
    // Address selection and sequential increment
    always_comb begin
        next_addr = pc;
        if (use_redirect) begin
            next_addr = redirect_pc;
        end else begin
            next_addr = pc;
        end
        next_pc = next_addr + INSTR_BYTES;
    end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: single-outstanding instruction-bus requests, a one-entry
// output buffer toward decode, and wrong-path discard on execute redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter u64 PC_RESET = PC_RESET_DEFAULT
)
(
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);
    fetch_state_t state_r, state_s;
    u64 pc_r, pc_s;
    u64 req_addr_r, req_addr_s;
    u1  out_valid_r, out_valid_s;
    u64 out_pc_r, out_pc_s;
    u32 out_instr_r, out_instr_s;
    u64 sel_addr_s, sel_pc_s;

    fetch_ctrl_pc_next u_pc_next (
        .pc           (pc_r),
        .redirect_pc  (bus.redirect_pc),
        .use_redirect (bus.redirect_valid),
        .next_addr    (sel_addr_s),
        .next_pc      (sel_pc_s)
    );

    // State and buffer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= FETCH;
            pc_r        <= PC_RESET + INSTR_BYTES;
            req_addr_r  <= PC_RESET;
            out_valid_r <= 1'b0;
            out_pc_r    <= 64'd0;
            out_instr_r <= 32'd0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            req_addr_r  <= req_addr_s;
            out_valid_r <= out_valid_s;
            out_pc_r    <= out_pc_s;
            out_instr_r <= out_instr_s;
        end
    end

    // Next-state and register update selection
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        req_addr_s  = req_addr_r;
        out_valid_s = out_valid_r;
        out_pc_s    = out_pc_r;
        out_instr_s = out_instr_r;
        case (state_r)
            FETCH: begin
                if (bus.redirect_valid) begin
                    // Same-cycle data is wrong-path; otherwise wait out the old request
                    if (bus.iresp_data_ok) begin
                        req_addr_s = sel_addr_s;
                        pc_s       = sel_pc_s;
                        state_s    = FETCH;
                    end else begin
                        pc_s    = bus.redirect_pc;
                        state_s = FLUSH;
                    end
                end else if (bus.iresp_data_ok) begin
                    out_valid_s = 1'b1;
                    out_pc_s    = req_addr_r;
                    out_instr_s = bus.iresp_data;
                    state_s     = HOLD;
                end else begin
                    state_s = FETCH;
                end
            end
            FLUSH: begin
                if (bus.iresp_data_ok) begin
                    req_addr_s = sel_addr_s;
                    pc_s       = sel_pc_s;
                    state_s    = FETCH;
                end else if (bus.redirect_valid) begin
                    pc_s    = bus.redirect_pc;
                    state_s = FLUSH;
                end else begin
                    state_s = FLUSH;
                end
            end
            HOLD: begin
                if (bus.redirect_valid || bus.out_ready) begin
                    out_valid_s = 1'b0;
                    req_addr_s  = sel_addr_s;
                    pc_s        = sel_pc_s;
                    state_s     = FETCH;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = FETCH;
            end
        endcase
    end

    assign bus.ireq_valid = (state_r != HOLD) && !reset;
    assign bus.ireq_addr  = req_addr_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_pc     = out_pc_r;
    assign bus.out_instr  = out_instr_r;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// checked against a transaction-level model of fetch, hold and redirect.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam logic [63:0] PCR = 64'h0000_0000_8000_0000;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.PC_RESET(PCR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: holding flag, outstanding address, next pc, wrong-path flag, buffer
    logic        m_ov;
    logic [63:0] m_addr;
    logic [63:0] m_next;
    logic        m_wrong;
    logic [63:0] m_opc;
    logic [31:0] m_oins;

    task automatic drive(input logic ok, input logic [31:0] dat, input logic rd,
                         input logic [63:0] rpc, input logic rdy);
        bus.iresp_data_ok  = ok;
        bus.iresp_data     = dat;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.iresp_data_ok = 1'b0; bus.iresp_data = 32'd0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 64'd0; bus.out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (bus.ireq_valid !== 1'b0) begin bad++; $display("FAIL reset_ireq_valid got=%0b want=0", bus.ireq_valid); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.out_pc !== 64'd0) begin bad++; $display("FAIL reset_out_pc got=%h want=0", bus.out_pc); end
        total++; if (bus.out_instr !== 32'd0) begin bad++; $display("FAIL reset_out_instr got=%h want=0", bus.out_instr); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (bus.ireq_valid !== 1'b1) begin bad++; $display("FAIL release_ireq_valid got=%0b want=1", bus.ireq_valid); end
        total++; if (bus.ireq_addr !== PCR) begin bad++; $display("FAIL release_ireq_addr got=%h want=%h", bus.ireq_addr, PCR); end
    endtask

    task automatic test_stream();
        logic [63:0] a;
        logic [31:0] d;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            a = PCR + 64'(4 * k);
            d = 32'h1000_0000 + 32'(k);
            total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== a) begin bad++; $display("FAIL stream_req k=%0d got=%0b/%h want=1/%h", k, bus.ireq_valid, bus.ireq_addr, a); end
            drive(1'b1, d, 1'b0, 64'd0, 1'b1);
            total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== a || bus.out_instr !== d) begin bad++; $display("FAIL stream_out k=%0d got=%0b/%h/%h want=1/%h/%h", k, bus.out_valid, bus.out_pc, bus.out_instr, a, d); end
            total++; if (bus.ireq_valid !== 1'b0) begin bad++; $display("FAIL stream_hold_noreq k=%0d got=%0b want=0", k, bus.ireq_valid); end
            drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_pulse k=%0d got=%0b want=0", k, bus.out_valid); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b1, 32'h0000_0013, 1'b0, 64'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
            total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== PCR || bus.out_instr !== 32'h0000_0013 || bus.ireq_valid !== 1'b0) begin
                bad++; $display("FAIL stall_hold k=%0d got=%0b/%h/%h/%0b want=1/%h/00000013/0", k, bus.out_valid, bus.out_pc, bus.out_instr, bus.ireq_valid, PCR);
            end
        end
        drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
        total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== PCR + 64'd4) begin bad++; $display("FAIL stall_release got=%0b/%h want=1/%h", bus.ireq_valid, bus.ireq_addr, PCR + 64'd4); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 32'h0000_0013, 1'b0, 64'd0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
        drive(1'b0, 32'd0, 1'b1, PCR + 64'h100, 1'b0);
        total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== PCR + 64'd4) begin bad++; $display("FAIL flush_hold_addr1 got=%0b/%h want=1/%h", bus.ireq_valid, bus.ireq_addr, PCR + 64'd4); end
        drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
        total++; if (bus.ireq_addr !== PCR + 64'd4 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_hold_addr2 got=%h/%0b want=%h/0", bus.ireq_addr, bus.out_valid, PCR + 64'd4); end
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 64'd0, 1'b1);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_discard got=%0b want=0", bus.out_valid); end
        total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== PCR + 64'h100) begin bad++; $display("FAIL flush_target got=%0b/%h want=1/%h", bus.ireq_valid, bus.ireq_addr, PCR + 64'h100); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h0000_0013, 1'b0, 64'd0, 1'b1);
            drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
        end
        total++; if (bus.ireq_addr !== PCR + 64'd8) begin bad++; $display("FAIL same_pre got=%h want=%h", bus.ireq_addr, PCR + 64'd8); end
        drive(1'b1, 32'hBAD0_0001, 1'b1, PCR + 64'h200, 1'b1);
        total++; if (bus.out_valid !== 1'b0 || bus.ireq_addr !== PCR + 64'h200 || bus.ireq_valid !== 1'b1) begin bad++; $display("FAIL same_redirect got=%0b/%h want=0/%h", bus.out_valid, bus.ireq_addr, PCR + 64'h200); end
        drive(1'b1, 32'h0000_0093, 1'b0, 64'd0, 1'b1);
        total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== PCR + 64'h200 || bus.out_instr !== 32'h0000_0093) begin bad++; $display("FAIL same_out got=%0b/%h/%h want=1/%h/00000093", bus.out_valid, bus.out_pc, bus.out_instr, PCR + 64'h200); end
        drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
        total++; if (bus.ireq_addr !== PCR + 64'h204) begin bad++; $display("FAIL same_next got=%h want=%h", bus.ireq_addr, PCR + 64'h204); end
    endtask

    task automatic test_hold_redirect();
        do_reset();
        drive(1'b1, 32'h0000_0013, 1'b0, 64'd0, 1'b0);
        drive(1'b0, 32'd0, 1'b1, PCR + 64'h300, 1'b1);
        total++; if (bus.out_valid !== 1'b0 || bus.ireq_valid !== 1'b1 || bus.ireq_addr !== PCR + 64'h300) begin bad++; $display("FAIL hold_redirect got=%0b/%0b/%h want=0/1/%h", bus.out_valid, bus.ireq_valid, bus.ireq_addr, PCR + 64'h300); end
        drive(1'b1, 32'h0000_0033, 1'b0, 64'd0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
        total++; if (bus.ireq_addr !== PCR + 64'h304) begin bad++; $display("FAIL hold_redirect_next got=%h want=%h", bus.ireq_addr, PCR + 64'h304); end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        drive(1'b1, 32'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        total++; if (bus.ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_req got=%h want=fffffffffffffffc", bus.ireq_addr); end
        drive(1'b1, 32'h0000_0073, 1'b0, 64'd0, 1'b0);
        total++; if (bus.out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || bus.out_valid !== 1'b1) begin bad++; $display("FAIL wrap_out got=%0b/%h want=1/fffffffffffffffc", bus.out_valid, bus.out_pc); end
        drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
        total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'd0) begin bad++; $display("FAIL wrap_next got=%0b/%h want=1/0", bus.ireq_valid, bus.ireq_addr); end
        reset = 1'b1;
        #1;
        total++; if (bus.out_pc !== 64'd0 || bus.out_instr !== 32'd0 || bus.out_valid !== 1'b0 || bus.ireq_valid !== 1'b0) begin
            bad++; $display("FAIL midreq_reset got=%0b/%h/%h/%0b want=0/0/0/0", bus.out_valid, bus.out_pc, bus.out_instr, bus.ireq_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== PCR) begin bad++; $display("FAIL midreq_release got=%0b/%h want=1/%h", bus.ireq_valid, bus.ireq_addr, PCR); end
    endtask

    task automatic test_random();
        logic        ok, rd, rdy;
        logic [31:0] dat;
        logic [63:0] rpc;
        do_reset();
        m_ov = 1'b0; m_addr = PCR; m_next = PCR + 64'd4; m_wrong = 1'b0;
        m_opc = 64'd0; m_oins = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            total++; if (bus.ireq_valid !== !m_ov) begin bad++; $display("FAIL rand_ireq_valid cyc=%0d got=%0b want=%0b", c, bus.ireq_valid, !m_ov); end
            total++; if (bus.ireq_addr !== m_addr) begin bad++; $display("FAIL rand_ireq_addr cyc=%0d got=%h want=%h", c, bus.ireq_addr, m_addr); end
            total++; if (bus.out_valid !== m_ov || bus.out_pc !== m_opc || bus.out_instr !== m_oins) begin
                bad++; $display("FAIL rand_out cyc=%0d got=%0b/%h/%h want=%0b/%h/%h", c, bus.out_valid, bus.out_pc, bus.out_instr, m_ov, m_opc, m_oins);
            end
            ok  = !m_ov && ($urandom_range(0, 2) != 0);
            dat = $urandom;
            rd  = ($urandom_range(0, 7) == 0);
            rpc = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {32'($urandom), 32'($urandom) & 32'hFFFF_FFFC};
            rdy = ($urandom_range(0, 2) != 0);
            bus.iresp_data_ok = ok; bus.iresp_data = dat;
            bus.redirect_valid = rd; bus.redirect_pc = rpc; bus.out_ready = rdy;
            @(posedge clk);
            // a redirect makes the current fetch wrong-path; data for a wrong-path fetch is dropped
            if (m_ov) begin
                if (rd) begin m_ov = 1'b0; m_addr = rpc; m_next = rpc + 64'd4; end
                else if (rdy) begin m_ov = 1'b0; m_addr = m_next; m_next = m_next + 64'd4; end
            end else begin
                if (rd && ok) begin m_addr = rpc; m_next = rpc + 64'd4; m_wrong = 1'b0; end
                else if (rd) begin m_next = rpc; m_wrong = 1'b1; end
                else if (ok && m_wrong) begin m_addr = m_next; m_next = m_next + 64'd4; m_wrong = 1'b0; end
                else if (ok) begin m_ov = 1'b1; m_opc = m_addr; m_oins = dat; end
            end
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.iresp_data_ok = 1'b0; bus.iresp_data = 32'd0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 64'd0; bus.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_same_cycle();
        test_hold_redirect();
        test_wrap_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences instruction fetch for the pipeline. It owns the fetch PC and drives a single-outstanding instruction-bus request. It holds the returned instruction in a one-entry output buffer until decode accepts it, and applies redirects from execute (branch/jump), discarding any in-flight or buffered wrong-path fetch. It sits between the instruction bus and the fetch/decode pipeline register.

Parameters:
PC_RESET, 64'h8000_0000, fetch PC loaded on reset.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
ireq_valid  output  1  instruction-bus request valid
ireq_addr  output  64  instruction-bus request address
iresp_data_ok  input  1  bus returns data for the outstanding request this cycle
iresp_data  input  32  instruction word, valid when iresp_data_ok=1
redirect_valid  input  1  execute redirects fetch this cycle
redirect_pc  input  64  redirect target
out_ready  input  1  decode accepts the buffered instruction (deasserted = stall)
out_valid  output  1  output buffer holds a valid instruction
out_pc  output  64  PC of the buffered instruction
out_instr  output  32  buffered instruction

Behaviour:
- Registers: state, pc (next PC to fetch), req_addr (address of the outstanding request), out_valid, out_pc, out_instr.
- Reset (async, any state, mid-request included):
  - state=FETCH, pc=PC_RESET+4, req_addr=PC_RESET.
  - out_valid=0, out_pc=0, out_instr=0.
  - ireq_valid=0 while reset is high.
  - A data_ok for a request issued before reset is not expected; the bus is reset together with this block.
- Bus rule: while ireq_valid=1, ireq_addr equals req_addr and is held stable until the cycle iresp_data_ok=1. At most one request is outstanding. ireq_valid=1 in FETCH and FLUSH only.
- States:
  - FETCH: request req_addr.
    - redirect_valid=1 takes priority in any cycle, regardless of data_ok. Then pc<=redirect_pc.
      - If data_ok=1 the same cycle: drop data, req_addr<=redirect_pc, pc<=redirect_pc+4, stay FETCH.
      - If data_ok=0: go to FLUSH.
    - Else if data_ok=1: out_valid<=1, out_pc<=req_addr, out_instr<=iresp_data, go to HOLD.
    - Else: stay in FETCH.
  - FLUSH: keep requesting the old req_addr until data_ok.
    - A new redirect overwrites pc (the latest redirect wins).
    - On data_ok: discard data, req_addr<=pc (or redirect_pc if redirect_valid the same cycle), pc<=that+4, go to FETCH.
  - HOLD: no request; out_valid=1.
    - redirect_valid=1 takes priority over out_ready: out_valid<=0, req_addr<=redirect_pc, pc<=redirect_pc+4, go to FETCH.
    - Else if out_ready=1: out_valid<=0, req_addr<=pc, pc<=pc+4, go to FETCH. The next request appears the following cycle.
    - Else: hold all outputs stable.
- Latency: the earliest out_valid is 1 cycle after the data_ok cycle. Steady-state throughput is 1 instruction per 2 cycles with a zero-wait bus.
- Arithmetic: pc+4 wraps modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC -> 0). redirect_pc is used unchanged; misalignment is checked downstream.
- Out buffer outputs change only on the transitions listed above.

Decomposition:
- common package: u1/u32/u64 types.
- pipes package: fetch_state_t enum {FETCH, FLUSH, HOLD}, PC_RESET default constant.
- One natural sub-module, fetch_pc_next (combinational): selects the next req_addr/pc pair from {pc, redirect_pc} and forms +4. All sequencing stays in fetch_ctrl.

Test Plan:
- Reset release, bus data_ok 1 cycle after each request, out_ready=1 -> ireq_addr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008. out_pc matches, with out_valid pulsing every 2nd cycle.
- out_ready=0 for 5 cycles while HOLD with out_pc=0x8000_0000, instr=0x00000013 -> outputs stable, ireq_valid=0 throughout. After out_ready=1, next ireq_addr=0x8000_0004.
- Request to 0x8000_0004 outstanding 3 cycles, redirect to 0x8000_0100 in cycle 1 -> ireq_addr stays 0x8000_0004 until data_ok. Data is discarded (out_valid stays 0), then ireq_addr=0x8000_0100.
- Redirect and data_ok in the same cycle for 0x8000_0008, target 0x8000_0200 -> no out_valid. Next request is 0x8000_0200, then 0x8000_0204.
- HOLD with out_valid=1, redirect to 0x8000_0300 and out_ready=1 the same cycle -> out_valid<=0, next ireq_addr=0x8000_0300.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC, then reset asserted mid-request -> first fetch wraps the next address to 0x0. After reset, outputs are 0 immediately and the first request after release is 0x8000_0000.
